// File: rtl/alu_mc_pkg.sv
// Shared opcodes, FSM encoding and iterative-unit mode for the multi-cycle ALU.
package alu_mc_pkg;

    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_SUB  = 4'b0110;
    localparam logic [3:0] ALU_SLT  = 4'b0111;
    localparam logic [3:0] ALU_NOR  = 4'b1100;
    localparam logic [3:0] ALU_MUL  = 4'b1000;
    localparam logic [3:0] ALU_DIVU = 4'b1001;
    localparam logic [3:0] ALU_REMU = 4'b1010;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef enum logic {
        MODE_MUL = 1'b0,
        MODE_DIV = 1'b1
    } iter_mode_t;

endpackage

// File: rtl/alu_mc_iter.sv
// Shared shift/accumulate datapath: unsigned shift-add multiply and restoring divide,
// one bit per cycle for WIDTH cycles. lo/hi present the post-step values so the caller
// can capture the final result on the same edge as the last step.
module alu_mc_iter
    import alu_mc_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  iter_mode_t       mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             finish,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] hi
);

    localparam int unsigned CW = $clog2(WIDTH + 1);

    logic             busy_q;
    logic [CW-1:0]    cnt_q;
    iter_mode_t       mode_q;
    // MUL: multiplicand; DIV: divisor
    logic [WIDTH-1:0] opnd_q;
    // MUL: {hi, lo} = {partial product, remaining multiplier}
    // DIV: hi = partial remainder, lo = dividend shifting out / quotient shifting in
    logic [WIDTH-1:0] lo_q, hi_q;
    logic [WIDTH-1:0] lo_d, hi_d;
    logic [WIDTH:0]   sum, shifted, diff;

    // One multiply or divide step from the current register contents.
    always_comb begin
        sum     = {1'b0, hi_q} + {1'b0, opnd_q};
        shifted = {hi_q, lo_q[WIDTH-1]};
        diff    = shifted - {1'b0, opnd_q};
        lo_d    = lo_q;
        hi_d    = hi_q;
        if (mode_q == MODE_MUL) begin
            if (lo_q[0]) begin
                hi_d = sum[WIDTH:1];
                lo_d = {sum[0], lo_q[WIDTH-1:1]};
            end else begin
                hi_d = {1'b0, hi_q[WIDTH-1:1]};
                lo_d = {hi_q[0], lo_q[WIDTH-1:1]};
            end
        end else begin
            // Borrow out of the (WIDTH+1)-bit subtract means shifted < divisor: restore.
            if (!diff[WIDTH]) begin
                hi_d = diff[WIDTH-1:0];
                lo_d = {lo_q[WIDTH-2:0], 1'b1};
            end else begin
                hi_d = shifted[WIDTH-1:0];
                lo_d = {lo_q[WIDTH-2:0], 1'b0};
            end
        end
    end

    assign finish = busy_q && (cnt_q == CW'(WIDTH - 1));
    assign lo     = lo_d;
    assign hi     = hi_d;

    // Operand load on start, then one step per cycle until the terminal count.
    always_ff @(posedge clk) begin
        if (reset) begin
            busy_q <= 1'b0;
            cnt_q  <= '0;
            mode_q <= MODE_MUL;
            opnd_q <= '0;
            lo_q   <= '0;
            hi_q   <= '0;
        end else if (start) begin
            busy_q <= 1'b1;
            cnt_q  <= '0;
            mode_q <= mode;
            hi_q   <= '0;
            if (mode == MODE_MUL) begin
                opnd_q <= a;
                lo_q   <= b;
            end else begin
                opnd_q <= b;
                lo_q   <= a;
            end
        end else if (busy_q) begin
            lo_q <= lo_d;
            hi_q <= hi_d;
            if (finish) begin
                busy_q <= 1'b0;
                cnt_q  <= '0;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU: single-cycle logic/arithmetic plus iterative MUL/DIVU/REMU behind
// valid/ready handshakes on input and output.
module alu_mc
    import alu_mc_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned OPW   = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [OPW-1:0]   operation,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result_hi,
    output logic             overflow,
    output logic             zero
);

    state_t           state_q, state_d;
    logic [OPW-1:0]   op_q;
    logic [WIDTH-1:0] result_q, result_hi_q;
    logic             overflow_q, zero_q;

    logic             is_mul, is_div, iter_op;
    logic             accept, load_single, load_iter, iter_start, iter_finish;
    logic [WIDTH-1:0] iter_lo, iter_hi, iter_res;
    logic [WIDTH-1:0] sum, diff, res_s, res_hi_s;
    logic             ov_s, slt;

    assign is_mul  = (operation == OPW'(ALU_MUL));
    assign is_div  = (operation == OPW'(ALU_DIVU)) || (operation == OPW'(ALU_REMU));
    // Divide by zero has a fixed answer, so it bypasses the iterative unit.
    assign iter_op = is_mul || (is_div && (b != '0));

    // Single-cycle result for everything that does not iterate.
    always_comb begin
        sum      = a + b;
        diff     = a - b;
        slt      = $signed(a) < $signed(b);
        res_s    = '0;
        res_hi_s = '0;
        ov_s     = 1'b0;
        case (operation)
            OPW'(ALU_AND): res_s = a & b;
            OPW'(ALU_OR):  res_s = a | b;
            OPW'(ALU_NOR): res_s = ~(a | b);
            OPW'(ALU_SLT): res_s = {{(WIDTH-1){1'b0}}, slt};
            OPW'(ALU_ADD): begin
                res_s = sum;
                ov_s  = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            end
            OPW'(ALU_SUB): begin
                res_s = diff;
                ov_s  = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
            end
            // Only reached with b == 0: quotient all-ones, remainder = dividend.
            OPW'(ALU_DIVU): begin
                res_s    = '1;
                res_hi_s = a;
            end
            OPW'(ALU_REMU): begin
                res_s    = a;
                res_hi_s = a;
            end
            default: ;
        endcase
    end

    alu_mc_iter #(
        .WIDTH (WIDTH)
    ) u_iter (
        .clk    (clk),
        .reset  (reset),
        .start  (iter_start),
        .mode   (is_mul ? MODE_MUL : MODE_DIV),
        .a      (a),
        .b      (b),
        .finish (iter_finish),
        .lo     (iter_lo),
        .hi     (iter_hi)
    );

    assign iter_res = (op_q == OPW'(ALU_REMU)) ? iter_hi : iter_lo;

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (in_valid) state_d = iter_op ? CALC : DONE;
            CALC: if (iter_finish) state_d = DONE;
            DONE: if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs and datapath load strobes.
    always_comb begin
        in_ready    = (state_q == IDLE);
        out_valid   = (state_q == DONE);
        accept      = in_ready && in_valid;
        load_single = accept && !iter_op;
        iter_start  = accept && iter_op;
        load_iter   = (state_q == CALC) && iter_finish;
    end

    // Result registers: held unchanged while the consumer stalls.
    always_ff @(posedge clk) begin
        if (reset) begin
            op_q        <= '0;
            result_q    <= '0;
            result_hi_q <= '0;
            overflow_q  <= 1'b0;
            zero_q      <= 1'b0;
        end else begin
            if (accept) begin
                op_q <= operation;
            end
            if (load_single) begin
                result_q    <= res_s;
                result_hi_q <= res_hi_s;
                overflow_q  <= ov_s;
                zero_q      <= (res_s == '0);
            end else if (load_iter) begin
                result_q    <= iter_res;
                result_hi_q <= iter_hi;
                overflow_q  <= 1'b0;
                zero_q      <= (iter_res == '0);
            end
        end
    end

    assign result    = result_q;
    assign result_hi = result_hi_q;
    assign overflow  = overflow_q;
    assign zero      = zero_q;

endmodule

// File: doc/alu_mc.md
Name: alu_mc

Overview:
Parametrised, multi-cycle successor to the 32-bit combinational ALU. It adds iterative unsigned multiply, divide and remainder to the single-cycle logic/arithmetic set, and puts a valid/ready handshake on both input and output. It sits between the decode/issue stage and writeback, and stalls issue through in_ready while an iterative operation runs.

Parameters:
WIDTH, 32, operand/result width in bits (>=4)
OPW, 4, operation code width

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
in_valid  input  1  operands/op presented
in_ready  output  1  block can accept an operation
a  input  WIDTH  operand A (multiplicand / dividend)
b  input  WIDTH  operand B (multiplier / divisor)
operation  input  OPW  operation code
out_valid  output  1  result registers hold a completed operation
out_ready  input  1  consumer takes the result
result  output  WIDTH  primary result
result_hi  output  WIDTH  MUL: upper product half; DIVU/REMU: remainder; otherwise 0
overflow  output  1  signed overflow (ADD/SUB only), else 0
zero  output  1  result == 0

Behaviour:
- Opcodes: AND 0000, OR 0001, ADD 0010, SUB 0110, SLT 0111 (signed, result 1/0), NOR 1100, MUL 1000, DIVU 1001 (result=quotient), REMU 1010 (result=remainder).
- Undefined opcode: result 0, result_hi 0, overflow 0, zero 1, single-cycle latency.
- Operation is accepted on a cycle with in_valid && in_ready. a, b and operation are captured in that cycle. Inputs are don't-care afterwards.
- FSM states:
  - IDLE: in_ready=1. Accept single-cycle op -> DONE. Accept MUL/DIVU/REMU -> CALC.
  - CALC: iterate exactly WIDTH cycles, then -> DONE.
  - DONE: out_valid=1. out_ready -> IDLE.
- in_ready=1 only in IDLE. There is no accept in the same cycle as the DONE handshake. Throughput is at most one op per 2 cycles.
- Latency from accept edge t: single-cycle ops give out_valid at t+1. Iterative ops give out_valid at t+WIDTH+1.
- Results are registered. They stay stable while out_valid && !out_ready, for an unbounded time.
- ADD/SUB wrap modulo 2^WIDTH. overflow = signed overflow of the WIDTH-bit operation.
- MUL: unsigned shift-add. Full 2*WIDTH product: {result_hi, result}.
- DIVU/REMU: unsigned restoring division, one quotient bit per cycle.
- Divide by zero (b==0): quotient all-ones, remainder = a. Skip CALC and go to DONE with single-cycle latency.
- zero is computed on the result port value only. result_hi is ignored for zero.
- Reset (any state, including mid-CALC): next state IDLE, in_ready=1, out_valid=0, result/result_hi=0, overflow=0, zero=0, iteration counter=0. The in-flight op is discarded.
- in_valid during CALC/DONE is ignored; the producer holds until in_ready.
- Iteration counter width is clog2(WIDTH+1). Terminal count is WIDTH-1 on the last CALC cycle.

Decomposition:
- Shared include alu_defs.vh holds:
  - opcode localparams/defines (ALU_AND … ALU_REMU)
  - FSM state encodings (IDLE=2'd0, CALC=2'd1, DONE=2'd2)
- The one natural sub-module is alu_mc_iter: the shared shift register/accumulator datapath for multiply and restoring divide. Its interface is start, mode, a, b, busy/finish, lo, hi.
- Single-cycle ops and the FSM stay in alu_mc.

Test Plan:
- WIDTH=32: a=0, b=32, ADD accepted at t -> out_valid at t+1, result=0x00000020, zero=0. Then a=20, b=32, ADD -> result=0x00000034.
- ADD 0x7FFFFFFF+0x00000001 -> result=0x80000000, overflow=1. SUB 5-5 -> result=0, zero=1, overflow=0. SLT 0xFFFFFFFF vs 1 -> result=1.
- MUL 0xFFFFFFFF*0x00000002 accepted at t -> in_ready=0 for t+1..t+33, out_valid at t+33, result=0xFFFFFFFE, result_hi=0x00000001.
- DIVU 100/7 -> result=14, result_hi=2 at t+33. REMU 100/7 -> result=2. DIVU 100/0 -> result=0xFFFFFFFF, result_hi=100 at t+1.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid -> result/out_valid unchanged, in_ready=0, new in_valid ignored. Release -> in_ready=1 next cycle.
- Reset asserted 5 cycles into a MUL -> next cycle in_ready=1, out_valid=0, result=0. A subsequent ADD 3+4 gives 7 at t+1.
